// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual-JTAG data register controller.
package vjtag_pkg;

    localparam int DR_W_DEF   = 24;
    localparam int STAT_W_DEF = 8;

    // Virtual IR command codes
    typedef enum logic [2:0] {
        CMD_BYPASS    = 3'd0,
        CMD_WR_TIME   = 3'd1,
        CMD_RD_TIME   = 3'd2,
        CMD_WR_ALARM  = 3'd3,
        CMD_RD_ALARM  = 3'd4,
        CMD_RD_STATUS = 3'd5,
        CMD_CLR_ERR   = 3'd6,
        CMD_BYPASS7   = 3'd7
    } cmd_e;

    // ir_out bit positions
    localparam int IR_ERR_BIT  = 2;
    localparam int IR_WROK_BIT = 1;
    localparam int IR_ONE_BIT  = 0;

    // Commands that drive tdo from the full shift register
    function automatic logic is_dr_cmd(input cmd_e c);
        return (c >= CMD_WR_TIME) && (c <= CMD_RD_STATUS);
    endfunction

    function automatic logic is_wr_cmd(input cmd_e c);
        return (c == CMD_WR_TIME) || (c == CMD_WR_ALARM);
    endfunction

endpackage

// File: rtl/vjtag_shreg.sv
// Shift register and saturating bit counter for the virtual DR.
module vjtag_shreg
    import vjtag_pkg::*;
#(
    parameter int DR_W   = DR_W_DEF,
    parameter int STAT_W = STAT_W_DEF,
    parameter int CNT_W  = $clog2(DR_W + 2)
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              cdr,
    input  logic              sdr,
    input  cmd_e              cmd,
    input  logic              tdi,
    input  logic [DR_W-1:0]   time_rd,
    input  logic [DR_W-1:0]   alarm_rd,
    input  logic [STAT_W-1:0] status,
    output logic [DR_W-1:0]   shreg,
    output logic [CNT_W-1:0]  cnt
);

    // Counter sticks one past DR_W so any over-shift stays distinguishable
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_W + 1);

    // Capture on CDR, shift LSB-out / tdi-in-MSB on SDR, hold otherwise
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (cdr) begin
            case (cmd)
                CMD_RD_TIME:   shreg <= time_rd;
                CMD_RD_ALARM:  shreg <= alarm_rd;
                CMD_RD_STATUS: shreg <= DR_W'(status);
                default:       shreg <= '0;
            endcase
            cnt <= '0;
        end else if (sdr) begin
            shreg <= {tdi, shreg[DR_W-1:1]};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vjtag_dr_ctrl.sv
// Virtual-JTAG DR controller: command decode, write strobes, error tracking.
module vjtag_dr_ctrl
    import vjtag_pkg::*;
#(
    parameter int DR_W   = DR_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [2:0]        ir_in,
    output logic [2:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    input  logic [DR_W-1:0]   time_rd_i,
    input  logic [DR_W-1:0]   alarm_rd_i,
    input  logic [STAT_W-1:0] status_i,
    output logic [DR_W-1:0]   wr_data_o,
    output logic              time_wr_stb_o,
    output logic              alarm_wr_stb_o,
    output logic              cmd_err_o
);

    localparam int CNT_W = $clog2(DR_W + 2);

    cmd_e             cmd_q;
    logic [DR_W-1:0]  shreg;
    logic [CNT_W-1:0] cnt;
    logic             byp;
    logic             err_sticky;
    logic             last_wr_ok;

    // Pause states need no action: shreg, counter and bypass simply hold
    logic unused_pause;
    assign unused_pause = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;

    // Resolve overlapping qualifiers: uir > cir > cdr > sdr > udr
    logic uir_e, cir_e, cdr_e, sdr_e, udr_e;
    assign uir_e = virtual_state_uir;
    assign cir_e = virtual_state_cir & ~uir_e;
    assign cdr_e = virtual_state_cdr & ~uir_e & ~virtual_state_cir;
    assign sdr_e = virtual_state_sdr & ~uir_e & ~virtual_state_cir & ~virtual_state_cdr;
    assign udr_e = virtual_state_udr & ~uir_e & ~virtual_state_cir & ~virtual_state_cdr
                   & ~virtual_state_sdr;

    logic wr_cmd, wr_ok, err_set, err_clr;
    assign wr_cmd  = is_wr_cmd(cmd_q);
    assign wr_ok   = (cnt == CNT_W'(DR_W));
    assign err_set = udr_e & wr_cmd & ~wr_ok;
    assign err_clr = udr_e & (cmd_q == CMD_CLR_ERR);

    vjtag_shreg #(
        .DR_W   (DR_W),
        .STAT_W (STAT_W),
        .CNT_W  (CNT_W)
    ) u_shreg (
        .tck      (tck),
        .rst_n    (rst_n),
        .cdr      (cdr_e),
        .sdr      (sdr_e),
        .cmd      (cmd_q),
        .tdi      (tdi),
        .time_rd  (time_rd_i),
        .alarm_rd (alarm_rd_i),
        .status   (status_i),
        .shreg    (shreg),
        .cnt      (cnt)
    );

    // Latch the virtual IR on Update-IR
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n)     cmd_q <= CMD_BYPASS;
        else if (uir_e) cmd_q <= cmd_e'(ir_in);
    end

    // One-bit bypass path used by BYPASS and CLR_ERR
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n)     byp <= 1'b0;
        else if (cdr_e) byp <= 1'b0;
        else if (sdr_e) byp <= tdi;
    end

    assign tdo = is_dr_cmd(cmd_q) ? shreg[0] : byp;

    // Update-DR: commit a full-length write or flag a length error; pulses last one cycle
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_o      <= '0;
            time_wr_stb_o  <= 1'b0;
            alarm_wr_stb_o <= 1'b0;
            cmd_err_o      <= 1'b0;
            last_wr_ok     <= 1'b0;
        end else begin
            time_wr_stb_o  <= 1'b0;
            alarm_wr_stb_o <= 1'b0;
            cmd_err_o      <= 1'b0;
            if (udr_e && wr_cmd) begin
                if (wr_ok) begin
                    wr_data_o      <= shreg;
                    time_wr_stb_o  <= (cmd_q == CMD_WR_TIME);
                    alarm_wr_stb_o <= (cmd_q == CMD_WR_ALARM);
                    last_wr_ok     <= 1'b1;
                end else begin
                    cmd_err_o  <= 1'b1;
                    last_wr_ok <= 1'b0;
                end
            end
        end
    end

    // Sticky error: a set in the same cycle as a clear takes precedence
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) err_sticky <= 1'b0;
        else        err_sticky <= err_set | (err_sticky & ~err_clr);
    end

    // IR capture word, refreshed on Capture-IR
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ir_out <= 3'b001;
        end else if (cir_e) begin
            ir_out[IR_ERR_BIT]  <= err_sticky;
            ir_out[IR_WROK_BIT] <= last_wr_ok;
            ir_out[IR_ONE_BIT]  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vjtag_dr_ctrl.sv
// Directed, table-driven bench for vjtag_dr_ctrl.
module tb_vjtag_dr_ctrl;

    logic        tck = 1'b0;
    logic        rst_n;
    logic        tdi;
    logic        tdo;
    logic [2:0]  ir_in;
    logic [2:0]  ir_out;
    logic        cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
    logic [23:0] time_rd_i, alarm_rd_i, wr_data_o;
    logic [7:0]  status_i;
    logic        time_wr_stb_o, alarm_wr_stb_o, cmd_err_o;

    int checks = 0;
    int errors = 0;

    always #5 tck = ~tck;

    vjtag_dr_ctrl dut (
        .tck               (tck),
        .rst_n             (rst_n),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_e1dr(e1dr),
        .virtual_state_pdr (pdr),
        .virtual_state_e2dr(e2dr),
        .virtual_state_udr (udr),
        .virtual_state_cir (cir),
        .virtual_state_uir (uir),
        .time_rd_i         (time_rd_i),
        .alarm_rd_i        (alarm_rd_i),
        .status_i          (status_i),
        .wr_data_o         (wr_data_o),
        .time_wr_stb_o     (time_wr_stb_o),
        .alarm_wr_stb_o    (alarm_wr_stb_o),
        .cmd_err_o         (cmd_err_o)
    );

    typedef struct {
        logic [2:0]  ir;
        logic [31:0] data;
        int          nbits;
        logic [23:0] exp_wr;
        logic        exp_ts;
        logic        exp_as;
        logic        exp_err;
        logic [2:0]  exp_ir;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic do_ir(input logic [2:0] code);
        ir_in = code; uir = 1'b1; step(); uir = 1'b0;
    endtask

    task automatic do_cdr();
        cdr = 1'b1; step(); cdr = 1'b0;
    endtask

    task automatic do_shift(input logic [31:0] data, input int n, input int first);
        for (int i = 0; i < n; i++) begin
            tdi = data[(first + i) % 32]; sdr = 1'b1; step(); sdr = 1'b0;
        end
        tdi = 1'b0;
    endtask

    task automatic do_udr();
        udr = 1'b1; step(); udr = 1'b0;
    endtask

    task automatic do_cir();
        cir = 1'b1; step(); cir = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_bits;

        rst_n = 1'b0; tdi = 1'b0; ir_in = 3'd0;
        {cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir} = '0;
        time_rd_i = 24'h0; alarm_rd_i = 24'h0; status_i = 8'h0;

        //            ir    data          n   exp_wr      ts  as  err exp_ir
        vecs[0] = '{3'd1, 32'h00123045, 24, 24'h123045, 1'b1, 1'b0, 1'b0, 3'b011};
        vecs[1] = '{3'd3, 32'h00070000, 24, 24'h070000, 1'b0, 1'b1, 1'b0, 3'b011};
        vecs[2] = '{3'd3, 32'h000ABCDE, 20, 24'h070000, 1'b0, 1'b0, 1'b1, 3'b101};
        vecs[3] = '{3'd2, 32'h00555555, 24, 24'h070000, 1'b0, 1'b0, 1'b0, 3'b101};
        vecs[4] = '{3'd6, 32'h00000000,  0, 24'h070000, 1'b0, 1'b0, 1'b0, 3'b001};
        vecs[5] = '{3'd1, 32'h00000001, 25, 24'h070000, 1'b0, 1'b0, 1'b1, 3'b101};
        vecs[6] = '{3'd6, 32'h00000000,  0, 24'h070000, 1'b0, 1'b0, 1'b0, 3'b001};
        vecs[7] = '{3'd1, 32'h00999999, 24, 24'h999999, 1'b1, 1'b0, 1'b0, 3'b011};
        vecs[8] = '{3'd5, 32'h000000FF,  8, 24'h999999, 1'b0, 1'b0, 1'b0, 3'b011};
        vecs[9] = '{3'd0, 32'h0000001F,  5, 24'h999999, 1'b0, 1'b0, 1'b0, 3'b011};

        // Reset state
        step(); step();
        chk("rst_ir_out", 32'(ir_out), 32'h1);
        chk("rst_wr_data", 32'(wr_data_o), 32'h0);
        chk("rst_pulses", 32'({time_wr_stb_o, alarm_wr_stb_o, cmd_err_o}), 32'h0);
        chk("rst_tdo", 32'(tdo), 32'h0);
        #3 rst_n = 1'b1;
        step();

        // Table of full IR/DR transactions
        time_rd_i = 24'h111111; status_i = 8'h3C;
        for (int v = 0; v < 10; v++) begin
            do_ir(vecs[v].ir);
            do_cdr();
            do_shift(vecs[v].data, vecs[v].nbits, 0);
            do_udr();
            chk($sformatf("v%0d_time_stb", v), 32'(time_wr_stb_o), 32'(vecs[v].exp_ts));
            chk($sformatf("v%0d_alarm_stb", v), 32'(alarm_wr_stb_o), 32'(vecs[v].exp_as));
            chk($sformatf("v%0d_err", v), 32'(cmd_err_o), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_wr_data", v), 32'(wr_data_o), 32'(vecs[v].exp_wr));
            step();
            chk($sformatf("v%0d_pulse_end", v),
                32'({time_wr_stb_o, alarm_wr_stb_o, cmd_err_o}), 32'h0);
            do_cir();
            chk($sformatf("v%0d_ir_out", v), 32'(ir_out), 32'(vecs[v].exp_ir));
        end

        // RD_TIME: tdo streams the captured time LSB first
        time_rd_i = 24'h235959; exp_bits = 32'h00235959;
        do_ir(3'd2);
        do_cdr();
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("rdtime_tdo%0d", i), 32'(tdo), 32'(exp_bits[i]));
            sdr = 1'b1; step(); sdr = 1'b0;
        end

        // RD_STATUS: status zero-extended, upper bits shift out as zero
        status_i = 8'hA5; exp_bits = 32'h000000A5;
        do_ir(3'd5);
        do_cdr();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rdstat_tdo%0d", i), 32'(tdo), 32'(exp_bits[i]));
            sdr = 1'b1; step(); sdr = 1'b0;
        end

        // Bypass bit under CLR_ERR
        do_ir(3'd6);
        do_cdr();
        chk("byp_cdr", 32'(tdo), 32'h0);
        tdi = 1'b1; sdr = 1'b1; step();
        chk("byp_one", 32'(tdo), 32'h1);
        tdi = 1'b0; step(); sdr = 1'b0;
        chk("byp_zero", 32'(tdo), 32'h0);

        // WR_ALARM with pause after bit 10, 30 bits total: counter saturates
        do_ir(3'd3);
        do_cdr();
        do_shift(32'h3FFFFFFF, 10, 0);
        e1dr = 1'b1; step(); e1dr = 1'b0;
        pdr  = 1'b1; step(); step(); step(); pdr = 1'b0;
        e2dr = 1'b1; step(); e2dr = 1'b0;
        do_shift(32'h3FFFFFFF, 20, 10);
        do_udr();
        chk("pause_stb", 32'({time_wr_stb_o, alarm_wr_stb_o}), 32'h0);
        chk("pause_err", 32'(cmd_err_o), 32'h1);
        chk("pause_wr_data", 32'(wr_data_o), 32'h999999);
        do_cir();
        chk("pause_ir_out", 32'(ir_out), 32'h5);

        // Priority: cir beats cdr, so capture is skipped while ir_out updates
        time_rd_i = 24'h000002;
        do_ir(3'd2);
        do_cdr();
        chk("prio_pre_tdo", 32'(tdo), 32'h0);
        time_rd_i = 24'h000003;
        ir_out_probe: begin
            cir = 1'b1; cdr = 1'b1; step(); cir = 1'b0; cdr = 1'b0;
        end
        chk("prio_tdo_hold", 32'(tdo), 32'h0);
        chk("prio_ir_out", 32'(ir_out), 32'h5);
        do_cdr();
        chk("prio_cdr_load", 32'(tdo), 32'h1);

        // Reset during a WR_TIME shift at bit 12
        do_ir(3'd1);
        do_cdr();
        do_shift(32'h00123045, 12, 0);
        rst_n = 1'b0;
        #2;
        chk("midrst_ir_out", 32'(ir_out), 32'h1);
        chk("midrst_wr_data", 32'(wr_data_o), 32'h0);
        chk("midrst_pulses", 32'({time_wr_stb_o, alarm_wr_stb_o, cmd_err_o}), 32'h0);
        chk("midrst_tdo", 32'(tdo), 32'h0);
        step(); step();
        #2 rst_n = 1'b1;
        step();
        do_ir(3'd1);
        do_udr();
        chk("postrst_stb", 32'({time_wr_stb_o, alarm_wr_stb_o}), 32'h0);
        chk("postrst_err", 32'(cmd_err_o), 32'h1);
        chk("postrst_wr_data", 32'(wr_data_o), 32'h0);
        do_cir();
        chk("postrst_ir_out", 32'(ir_out), 32'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
